// File: rtl/gelato_types.sv
// Shared GPU front-end types: instruction-buffer entry, widths and default depth.
package gelato_types;
  localparam int GELATO_NUM_WARPS = 8;
  localparam int WARP_NUM_W       = $clog2(GELATO_NUM_WARPS);
  localparam int PC_W             = 32;
  localparam int THREAD_MASK_W    = 32;
  localparam int INST_W           = 32;
  localparam int IBUFFER_DEPTH    = 2;

  typedef logic [INST_W-1:0] inst_t;

  typedef struct packed {
    logic [PC_W-1:0]          pc;
    logic [THREAD_MASK_W-1:0] thread_mask;
    inst_t                    inst;
  } ibuffer_entry_t;
endpackage

// File: rtl/gelato_idecode_ibuffer_if.sv
// I-Decode -> I-Buffer write channel: one decoded instruction per cycle.
interface gelato_idecode_ibuffer_if
  import gelato_types::*;
#(
  parameter int NUM_WARPS = GELATO_NUM_WARPS
);
  logic                         valid;
  logic [PC_W-1:0]              pc;
  logic [$clog2(NUM_WARPS)-1:0] warp_num;
  logic [THREAD_MASK_W-1:0]     thread_mask;
  inst_t                        inst;

  modport master (output valid, pc, warp_num, thread_mask, inst);
  modport slave  (input  valid, pc, warp_num, thread_mask, inst);
endinterface

// File: rtl/gelato_ibuffer_fifo.sv
// Single-warp instruction FIFO; flush beats push/pop, push into a full FIFO
// is only accepted when the same cycle pops.
module gelato_ibuffer_fifo
  import gelato_types::*;
#(
  parameter  int DEPTH = IBUFFER_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  ibuffer_entry_t push_data,
  input  logic           pop,
  input  logic           flush,
  output ibuffer_entry_t head,
  output logic [CW-1:0]  count
);
  ibuffer_entry_t mem [DEPTH];
  logic [PW-1:0]  head_ptr, tail_ptr;
  logic           do_push, do_pop;

  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop) && !flush;
  assign head    = mem[head_ptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= tail_ptr;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + PW'(1);
      if (do_pop)  head_ptr <= head_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/gelato_ibuffer.sv
// Per-warp instruction buffer: write demux, head mux, sticky overflow flag.
// Optional per-warp flush port enabled by defining GELATO_IBUFFER_FLUSH_EN.
module gelato_ibuffer
  import gelato_types::*;
#(
  parameter  int NUM_WARPS = GELATO_NUM_WARPS,
  parameter  int DEPTH     = IBUFFER_DEPTH,
  localparam int WW        = $clog2(NUM_WARPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gelato_idecode_ibuffer_if.slave  idecode,
  output logic [NUM_WARPS-1:0]     ibuffer_full,
  output logic [NUM_WARPS-1:0]     issue_valid,
  input  logic [WW-1:0]            issue_warp_num,
  input  logic                     issue_pop,
  output ibuffer_entry_t           issue_entry,
  output logic                     overflow_err
`ifdef GELATO_IBUFFER_FLUSH_EN
  ,
  input  logic [NUM_WARPS-1:0]     flush
`endif
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_WARPS-1:0]          push, pop, flush_w;
  logic [NUM_WARPS-1:0][CW-1:0]  counts;
  ibuffer_entry_t                heads [NUM_WARPS];
  ibuffer_entry_t                wr_entry;
  logic                          drop;

`ifdef GELATO_IBUFFER_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = '0;
`endif

  assign wr_entry = '{pc: idecode.pc, thread_mask: idecode.thread_mask, inst: idecode.inst};

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign push[w]         = idecode.valid && (idecode.warp_num == WW'(w));
    assign pop[w]          = issue_pop && (issue_warp_num == WW'(w));
    assign ibuffer_full[w] = (counts[w] == CW'(DEPTH));
    assign issue_valid[w]  = (counts[w] != '0);

    gelato_ibuffer_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[w]),
      .push_data (wr_entry),
      .pop       (pop[w]),
      .flush     (flush_w[w]),
      .head      (heads[w]),
      .count     (counts[w])
    );
  end

  assign issue_entry = heads[issue_warp_num];

  // A write is lost only when full with no effective pop to free the slot; flush is not an error.
  assign drop = |(push & ibuffer_full & ~(pop & issue_valid) & ~flush_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    overflow_err <= 1'b0;
    else if (drop) overflow_err <= 1'b1;
  end
endmodule

// File: tb/tb_gelato_ibuffer.sv
// Directed self-checking bench for gelato_ibuffer (flush test when GELATO_IBUFFER_FLUSH_EN).
module tb_gelato_ibuffer;
  import gelato_types::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     ibuffer_full, issue_valid;
  logic [2:0]     issue_warp_num = '0;
  logic           issue_pop = 1'b0;
  ibuffer_entry_t issue_entry;
  logic           overflow_err;
`ifdef GELATO_IBUFFER_FLUSH_EN
  logic [7:0]     flush = '0;
`endif
  int checks = 0;
  int errors = 0;

  gelato_idecode_ibuffer_if #(.NUM_WARPS(8)) idec ();

  gelato_ibuffer #(.NUM_WARPS(8), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .idecode        (idec.slave),
    .ibuffer_full   (ibuffer_full),
    .issue_valid    (issue_valid),
    .issue_warp_num (issue_warp_num),
    .issue_pop      (issue_pop),
    .issue_entry    (issue_entry),
    .overflow_err   (overflow_err)
`ifdef GELATO_IBUFFER_FLUSH_EN
    ,
    .flush          (flush)
`endif
  );

  always #5 clk = ~clk;

  // One clock of stimulus: inputs set at negedge, released 1ns after the posedge.
  task automatic drive(input logic pv, input logic [2:0] pw, input logic [31:0] pc,
                       input logic ov, input logic [2:0] ow);
    @(negedge clk);
    idec.valid = pv; idec.warp_num = pw; idec.pc = pc;
    idec.thread_mask = ~pc; idec.inst = pc + 32'h1000;
    issue_pop = ov; issue_warp_num = ow;
    @(posedge clk); #1;
    idec.valid = 1'b0; issue_pop = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idec.valid = 1'b0; idec.warp_num = '0; idec.pc = '0; idec.thread_mask = '0; idec.inst = '0;
    rst_n = 1'b0;
    #12;
    checks++; if (issue_valid !== 8'h00) begin errors++; $display("FAIL reset_valid got %h exp 00", issue_valid); end
    checks++; if (ibuffer_full !== 8'h00) begin errors++; $display("FAIL reset_full got %h exp 00", ibuffer_full); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow_err); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    drive(1, 3, 32'h100, 0, 3);
    checks++; if (issue_valid[3] !== 1'b1) begin errors++; $display("FAIL fd_valid1 got %b exp 1", issue_valid[3]); end
    checks++; if (ibuffer_full[3] !== 1'b0) begin errors++; $display("FAIL fd_full1 got %b exp 0", ibuffer_full[3]); end
    checks++; if (issue_entry.pc !== 32'h100) begin errors++; $display("FAIL fd_head1 got %h exp 100", issue_entry.pc); end
    checks++; if (issue_entry.thread_mask !== 32'hFFFF_FEFF) begin errors++; $display("FAIL fd_mask got %h exp fffffeff", issue_entry.thread_mask); end
    checks++; if (issue_entry.inst !== 32'h1100) begin errors++; $display("FAIL fd_inst got %h exp 1100", issue_entry.inst); end
    drive(1, 3, 32'h104, 0, 3);
    checks++; if (ibuffer_full[3] !== 1'b1) begin errors++; $display("FAIL fd_full2 got %b exp 1", ibuffer_full[3]); end
    checks++; if (issue_entry.pc !== 32'h100) begin errors++; $display("FAIL fd_head2 got %h exp 100", issue_entry.pc); end
    drive(0, 0, 0, 1, 3);
    checks++; if (issue_entry.pc !== 32'h104) begin errors++; $display("FAIL fd_pop1 got %h exp 104", issue_entry.pc); end
    checks++; if (ibuffer_full[3] !== 1'b0) begin errors++; $display("FAIL fd_full3 got %b exp 0", ibuffer_full[3]); end
    drive(0, 0, 0, 1, 3);
    checks++; if (issue_valid !== 8'h00) begin errors++; $display("FAIL fd_empty got %h exp 00", issue_valid); end
  endtask

  task automatic test_overflow();
    drive(1, 5, 32'h500, 0, 5);
    drive(1, 5, 32'h504, 0, 5);
    drive(1, 5, 32'h200, 0, 5);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow_err); end
    checks++; if (issue_entry.pc !== 32'h500) begin errors++; $display("FAIL ovf_head got %h exp 500", issue_entry.pc); end
    checks++; if (ibuffer_full[5] !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", ibuffer_full[5]); end
    drive(0, 0, 0, 1, 5);
    drive(0, 0, 0, 0, 5);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow_err); end
    checks++; if (issue_entry.pc !== 32'h504) begin errors++; $display("FAIL ovf_second got %h exp 504", issue_entry.pc); end
    drive(0, 0, 0, 1, 5);
    checks++; if (issue_valid[5] !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", issue_valid[5]); end
    pulse_reset();
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow_err); end
  endtask

  task automatic test_full_push_pop();
    drive(1, 2, 32'h2a0, 0, 2);
    drive(1, 2, 32'h2a4, 0, 2);
    drive(1, 2, 32'h300, 1, 2);
    checks++; if (ibuffer_full[2] !== 1'b1) begin errors++; $display("FAIL fpp_full got %b exp 1", ibuffer_full[2]); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b exp 0", overflow_err); end
    checks++; if (issue_entry.pc !== 32'h2a4) begin errors++; $display("FAIL fpp_head1 got %h exp 2a4", issue_entry.pc); end
    drive(0, 0, 0, 1, 2);
    checks++; if (issue_entry.pc !== 32'h300) begin errors++; $display("FAIL fpp_head2 got %h exp 300", issue_entry.pc); end
    drive(0, 0, 0, 1, 2);
    checks++; if (issue_valid[2] !== 1'b0) begin errors++; $display("FAIL fpp_empty got %b exp 0", issue_valid[2]); end
  endtask

  task automatic test_cross_warp();
    drive(1, 7, 32'h700, 0, 7);
    drive(1, 0, 32'h010, 1, 7);
    checks++; if (issue_valid !== 8'h01) begin errors++; $display("FAIL xw_valid got %h exp 01", issue_valid); end
    checks++; if (ibuffer_full !== 8'h00) begin errors++; $display("FAIL xw_full got %h exp 00", ibuffer_full); end
    issue_warp_num = 3'd0; #1;
    checks++; if (issue_entry.pc !== 32'h010) begin errors++; $display("FAIL xw_head got %h exp 010", issue_entry.pc); end
    drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_pop_empty_and_reset();
    drive(1, 1, 32'h110, 0, 4);
    drive(0, 0, 0, 1, 4);
    checks++; if (issue_valid !== 8'h02) begin errors++; $display("FAIL pe_valid got %h exp 02", issue_valid); end
    checks++; if (ibuffer_full !== 8'h00) begin errors++; $display("FAIL pe_full got %h exp 00", ibuffer_full); end
    drive(1, 4, 32'h440, 0, 4);
    checks++; if (issue_entry.pc !== 32'h440) begin errors++; $display("FAIL pe_push got %h exp 440", issue_entry.pc); end
    drive(1, 1, 32'h114, 0, 1);
    checks++; if (issue_valid !== 8'h12) begin errors++; $display("FAIL pe_traffic got %h exp 12", issue_valid); end
    // Reset lands mid-traffic: a push is pending and flags must drop without a clock.
    @(negedge clk);
    idec.valid = 1'b1; idec.warp_num = 3'd6; idec.pc = 32'h600;
    rst_n = 1'b0; #1;
    checks++; if (issue_valid !== 8'h00) begin errors++; $display("FAIL rst_async_valid got %h exp 00", issue_valid); end
    checks++; if (ibuffer_full !== 8'h00) begin errors++; $display("FAIL rst_async_full got %h exp 00", ibuffer_full); end
    @(negedge clk); rst_n = 1'b1; idec.valid = 1'b0; #1;
    checks++; if (issue_valid !== 8'h00) begin errors++; $display("FAIL rst_drop got %h exp 00", issue_valid); end
    drive(1, 6, 32'h660, 0, 6);
    checks++; if (issue_entry.pc !== 32'h660) begin errors++; $display("FAIL rst_resume got %h exp 660", issue_entry.pc); end
    checks++; if (issue_valid !== 8'h40) begin errors++; $display("FAIL rst_resume_v got %h exp 40", issue_valid); end
  endtask

`ifdef GELATO_IBUFFER_FLUSH_EN
  task automatic test_flush();
    drive(1, 1, 32'h410, 0, 1);
    drive(1, 1, 32'h414, 0, 1);
    @(negedge clk);
    flush = 8'h02; idec.valid = 1'b1; idec.warp_num = 3'd1; idec.pc = 32'h400;
    @(posedge clk); #1;
    flush = 8'h00; idec.valid = 1'b0;
    checks++; if (issue_valid[1] !== 1'b0) begin errors++; $display("FAIL fl_valid got %b exp 0", issue_valid[1]); end
    checks++; if (ibuffer_full[1] !== 1'b0) begin errors++; $display("FAIL fl_full got %b exp 0", ibuffer_full[1]); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL fl_ovf got %b exp 0", overflow_err); end
    drive(1, 1, 32'h420, 0, 1);
    checks++; if (issue_entry.pc !== 32'h420) begin errors++; $display("FAIL fl_after got %h exp 420", issue_entry.pc); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_cross_warp();
    test_pop_empty_and_reset();
`ifdef GELATO_IBUFFER_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gelato_ibuffer.md
GELATO_IBUFFER -- requirements
Module: gelato_ibuffer

Interface
REQ-001 SHALL have parameter NUM_WARPS, 8, number of warps; one FIFO per warp.
REQ-002 SHALL have parameter DEPTH, 2, entries per warp FIFO; power of two, at least 2.
REQ-003 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n input 1: asynchronous active-low reset.
REQ-005 SHALL have port idecode slave-modport of gelato_idecode_ibuffer_if: valid, pc, warp_num, thread_mask, inst from I-Decode.
REQ-006 SHALL have port ibuffer_full output NUM_WARPS: per-warp full flag to warp scheduler.
REQ-007 SHALL have port issue_valid output NUM_WARPS: per-warp non-empty flag.
REQ-008 SHALL have port issue_warp_num input $clog2(NUM_WARPS): warp selected by issue stage.
REQ-009 SHALL have port issue_pop input 1: dequeue head of issue_warp_num this cycle.
REQ-010 SHALL have port issue_entry output ibuffer_entry_t: head entry (pc, thread_mask, inst) of issue_warp_num.
REQ-011 SHALL have port overflow_err output 1: sticky error flag.

Function
REQ-012 SHALL, on idecode.valid, write {pc, thread_mask, inst} into the FIFO indexed by idecode.warp_num at the tail; entry visible at head no earlier than the next cycle.
REQ-013 SHALL drive issue_entry combinationally from the head of the selected warp FIFO; value undefined-but-stable when that FIFO is empty.
REQ-014 SHALL, on issue_pop with issue_valid[issue_warp_num]=1, advance that FIFO's head pointer at the next edge.
REQ-015 SHALL ignore issue_pop when issue_valid[issue_warp_num]=0; no pointer or count change.
REQ-016 SHALL keep per-warp count 0..DEPTH; ibuffer_full[w]=(count==DEPTH); issue_valid[w]=(count!=0); both derived from registered state only.
REQ-017 SHALL, on a write and a pop to the same warp in one cycle, perform both; count unchanged; this is legal even when full (pop frees the slot).
REQ-018 SHALL, on a write to a full warp without a same-cycle pop of that warp, drop the write, leave that FIFO untouched, and set overflow_err=1 until reset.
REQ-019 SHALL allow a write and a pop to different warps in the same cycle, each independent.
REQ-020 SHALL wrap head/tail pointers modulo DEPTH with no bubble.
REQ-021 SHALL preserve per-warp program order; no ordering across warps is implied.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear all pointers and counts, making issue_valid=0, ibuffer_full=0, and overflow_err=0; entry storage is not reset.
REQ-023 SHALL drop any in-flight write or pop coincident with reset; operation resumes on the first edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with GELATO_IBUFFER_FLUSH_EN defined, add port flush input NUM_WARPS: flush[w] empties warp w at the next edge (count=0, head=tail).
REQ-025 SHALL, with flush enabled, let flush win over a same-cycle write or pop to that warp: write dropped, no overflow_err, pop ignored.
REQ-026 SHALL, without GELATO_IBUFFER_FLUSH_EN, have no flush port and no flush logic.

Structure
REQ-027 SHALL define ibuffer_entry_t (pc, thread_mask, inst_t) and IBUFFER_DEPTH default in gelato_types; warp-number width comes from existing package constants.
REQ-028 SHALL implement each warp FIFO as sub-module gelato_ibuffer_fifo (push, pop, flush, head, count), instantiated NUM_WARPS times via generate; top holds demux, head mux, and error flag.

Verification
REQ-029 SHALL cover: push warp 3 pc=0x100 then 0x104 -> issue_valid[3]=1, ibuffer_full[3]=1, pops return 0x100 then 0x104, then issue_valid[3]=0.
REQ-030 SHALL cover: warp 5 full, push pc=0x200 without pop -> write dropped, overflow_err=1 sticky, head still original entry.
REQ-031 SHALL cover: warp 2 full, same-cycle push 0x300 and pop -> count stays 2, overflow_err=0, order preserved.
REQ-032 SHALL cover: push warp 0 while popping warp 7 in one cycle -> both take effect, counts 1 and 0.
REQ-033 SHALL cover: pop of empty warp 4 -> no state change; rst_n pulse mid-traffic -> all issue_valid=0 immediately.
REQ-034 SHALL cover (FLUSH_EN): warp 1 holds 2 entries, flush[1] with push 0x400 -> warp 1 empty next cycle, overflow_err=0.
